// File: rtl/layer_serializer_pkg.sv
// Shared network package: FSM state typedefs used by the layer blocks
// and a helper that sizes word-index counters.
package layer_serializer_pkg;

  // Occupancy of the serializer's ping-pong buffers.
  typedef enum logic [1:0] {
    eEMPTY = 2'd0,
    eONE   = 2'd1,
    eTWO   = 2'd2
  } occ_state_e;

  // Compute-layer sequencing state, shared with the upstream layers.
  typedef enum logic [1:0] {
    eLAYER_IDLE = 2'd0,
    eLAYER_LOAD = 2'd1,
    eLAYER_RUN  = 2'd2,
    eLAYER_DONE = 2'd3
  } layer_state_e;

  // Index width that stays at least 1 bit, so N_WORDS=1 still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_serializer_vector.sv
// vector_buffer: one whole-vector storage slot with a full flag.
// Ports:
//   clk_i, reset_n_i : clock, synchronous active-low reset (clears full only)
//   load_i           : capture data_i and set full
//   clear_i          : drop full (last word of this vector consumed)
//   sel_i            : word index to present on data_o
//   data_i           : packed vector, element [k] is word k
//   data_o           : selected word
//   full_o           : slot holds an unread vector
module vector_buffer
  import layer_serializer_pkg::*;
#(
  parameter int N_WORDS   = 256,
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = idx_width(N_WORDS)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             load_i,
  input  logic                             clear_i,
  input  logic [IDX_W-1:0]                 sel_i,
  input  logic [N_WORDS-1:0][WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0]             data_o,
  output logic                             full_o
);

  logic [N_WORDS-1:0][WORD_SIZE-1:0] r_mem;
  logic                              r_full;

  // Contents are deliberately not reset; the full flag gates their use.
  always_ff @(posedge clk_i) begin
    if (load_i) r_mem <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)   r_full <= 1'b0;
    else if (load_i)  r_full <= 1'b1;
    else if (clear_i) r_full <= 1'b0;
  end

  assign data_o = r_mem[sel_i];
  assign full_o = r_full;

endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: accepts whole vectors of N_WORDS words and emits them one
// word at a time, ascending, through a ping-pong pair of vector buffers.
// Ports:
//   clk_i, reset_n_i   : clock, synchronous active-low reset
//   valid_i, ready_o   : upstream vector handshake
//   data_i             : packed input vector, element [k] is word k
//   valid_o, yumi_i    : downstream word handshake (yumi only while valid_o)
//   data_o, last_o     : current word, high on word N_WORDS-1
//
// state  | meaning
// eEMPTY | no buffer full, accepting
// eONE   | one buffer full, accepting into the other
// eTWO   | both full, not accepting
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int N_WORDS   = 256,
  parameter int WORD_SIZE = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [N_WORDS-1:0][WORD_SIZE-1:0] data_i,
  output logic                              valid_o,
  input  logic                              yumi_i,
  output logic [WORD_SIZE-1:0]              data_o,
  output logic                              last_o
);

  localparam int IDX_W = idx_width(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  occ_state_e       r_state;
  logic             r_wsel;
  logic             r_rsel;
  logic [IDX_W-1:0] r_rd_idx;

  logic                 w_cap;
  logic                 w_rel;
  logic                 w_full0, w_full1;
  logic [WORD_SIZE-1:0] w_data0, w_data1;

  // Gating with reset_n_i keeps ready low while reset is held; there is no
  // path from valid_i or yumi_i.
  assign ready_o = reset_n_i && (r_state != eTWO);
  assign valid_o = r_rsel ? w_full1 : w_full0;
  assign data_o  = r_rsel ? w_data1 : w_data0;
  assign last_o  = valid_o && (r_rd_idx == LAST_IDX);

  assign w_cap = valid_i && ready_o;
  assign w_rel = valid_o && yumi_i && (r_rd_idx == LAST_IDX);

  vector_buffer #(.N_WORDS(N_WORDS), .WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) u_buf0 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (w_cap && !r_wsel),
    .clear_i   (w_rel && !r_rsel),
    .sel_i     (r_rd_idx),
    .data_i    (data_i),
    .data_o    (w_data0),
    .full_o    (w_full0)
  );

  vector_buffer #(.N_WORDS(N_WORDS), .WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) u_buf1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (w_cap && r_wsel),
    .clear_i   (w_rel && r_rsel),
    .sel_i     (r_rd_idx),
    .data_i    (data_i),
    .data_o    (w_data1),
    .full_o    (w_full1)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= eEMPTY;
      r_wsel   <= 1'b0;
      r_rsel   <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      if (w_cap) r_wsel <= ~r_wsel;

      if (valid_o && yumi_i) begin
        if (w_rel) begin
          r_rd_idx <= '0;
          r_rsel   <= ~r_rsel;
        end else begin
          r_rd_idx <= r_rd_idx + IDX_W'(1);
        end
      end

      // A capture and a release in the same cycle cancel out.
      case (r_state)
        eEMPTY:  if (w_cap) r_state <= eONE;
        eONE: begin
          if (w_cap && !w_rel)      r_state <= eTWO;
          else if (!w_cap && w_rel) r_state <= eEMPTY;
        end
        eTWO:    if (w_rel) r_state <= eONE;
        default: r_state <= eEMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

  localparam int NW = 4;
  localparam int WS = 16;

  logic                   clk_i = 1'b0;
  logic                   reset_n_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [NW-1:0][WS-1:0]  data_i;
  logic                   valid_o;
  logic                   yumi_i;
  logic [WS-1:0]          data_o;
  logic                   last_o;

  int n_chk  = 0;
  int n_pass = 0;

  layer_serializer #(.N_WORDS(NW), .WORD_SIZE(WS)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .yumi_i    (yumi_i),
    .data_o    (data_o),
    .last_o    (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [NW-1:0][WS-1:0] mkvec(input logic [WS-1:0] base);
    logic [NW-1:0][WS-1:0] v;
    for (int k = 0; k < NW; k++) v[k] = base + WS'(k);
    return v;
  endfunction

  // Check the word presented now, then consume it on the next edge.
  task automatic take(input string tag, input logic [WS-1:0] exp, input logic exp_last);
    yumi_i = 1'b1;
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"},  32'(data_o),  32'(exp));
    chk({tag, "_last"},  32'(last_o),  32'(exp_last));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    logic [WS-1:0] exp_w;

    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    yumi_i    = 1'b0;
    data_i    = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last",  32'(last_o),  32'd0);
    reset_n_i = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_valid", 32'(valid_o), 32'd0);

    // Single vector {1,2,3,4}, yumi held high.
    valid_i = 1'b1;
    data_i  = mkvec(16'd1);
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < NW; k++) take("v1", WS'(k + 1), k == NW - 1);
    yumi_i = 1'b0;
    chk("v1_drained", 32'(valid_o), 32'd0);

    // Two back-to-back vectors with no consumption fill both buffers.
    chk("b2b_ready0", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    data_i  = mkvec(16'h0010);
    tick();
    chk("b2b_ready1", 32'(ready_o), 32'd1);
    data_i = mkvec(16'h0020);
    tick();
    chk("b2b_ready_two", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    tick();
    chk("two_hold_data", 32'(data_o), 32'h10);

    // Drain first vector; offer a third vector during the last-word cycle.
    for (int k = 0; k < NW; k++) begin
      if (k == NW - 1) begin
        chk("two_last_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b1;
        data_i  = mkvec(16'h0030);
      end
      take("v10", 16'h0010 + WS'(k), k == NW - 1);
    end
    chk("two_resume_ready", 32'(ready_o), 32'd1);
    take("v20", 16'h0020, 1'b0);
    valid_i = 1'b0;
    chk("third_full_ready", 32'(ready_o), 32'd0);
    for (int k = 1; k < NW; k++) take("v20", 16'h0020 + WS'(k), k == NW - 1);

    // In eONE: capture a fourth vector in the same cycle as the final yumi.
    for (int k = 0; k < NW; k++) begin
      if (k == NW - 1) begin
        chk("one_cap_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        data_i  = mkvec(16'h0040);
      end
      take("v30", 16'h0030 + WS'(k), k == NW - 1);
    end
    valid_i = 1'b0;
    chk("one_stays_ready", 32'(ready_o), 32'd1);
    for (int k = 0; k < NW; k++) take("v40", 16'h0040 + WS'(k), k == NW - 1);
    yumi_i = 1'b0;
    chk("v40_drained", 32'(valid_o), 32'd0);

    // Random stalls across two queued vectors.
    valid_i = 1'b1;
    data_i  = mkvec(16'h0050);
    tick();
    data_i = mkvec(16'h0060);
    tick();
    valid_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 2 * NW && cyc < 200) begin
      exp_w  = (idx < NW) ? 16'h0050 + WS'(idx) : 16'h0060 + WS'(idx - NW);
      yumi_i = 1'($urandom_range(0, 1));
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_data",  32'(data_o),  32'(exp_w));
      chk("stall_last",  32'(last_o),  32'((idx % NW) == NW - 1));
      tick();
      if (yumi_i) idx++;
      cyc++;
    end
    yumi_i = 1'b0;
    chk("stall_words_done", 32'(idx), 32'(2 * NW));
    chk("stall_drained", 32'(valid_o), 32'd0);

    // yumi while idle must change nothing.
    yumi_i = 1'b1;
    tick();
    tick();
    yumi_i = 1'b0;
    chk("idle_yumi_valid", 32'(valid_o), 32'd0);
    chk("idle_yumi_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    data_i  = mkvec(16'h0070);
    tick();
    valid_i = 1'b0;
    chk("idle_yumi_word0", 32'(data_o), 32'h70);

    // Reset after two words consumed discards the remainder.
    take("v70", 16'h0070, 1'b0);
    take("v70", 16'h0071, 1'b0);
    yumi_i    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_ready_after", 32'(ready_o), 32'd1);
    chk("mid_rst_last", 32'(last_o), 32'd0);
    tick();
    tick();
    chk("mid_rst_no_stale", 32'(valid_o), 32'd0);
    valid_i = 1'b1;
    data_i  = mkvec(16'h0090);
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < NW; k++) take("v90", 16'h0090 + WS'(k), k == NW - 1);
    yumi_i = 1'b0;
    chk("v90_drained", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
